gcm_aes: RTL and testbench
==========================

Name: gcm_aes

Overview:
- AES-128 Galois/Counter Mode authenticated encryptor per NIST SP 800-38D, 96-bit IV only.
- Streams AAD blocks, then plaintext blocks, one 128-bit block per cycle.
- Emits each ciphertext block one cycle after it is accepted, then the 128-bit tag.
- Sits between a block-streaming host and the tag/ciphertext consumer; there is no back-pressure.

Parameters:
- None. Key width fixed at 128, IV at 96, block at 128, sizes at 64.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- i_new_instance  in  1  start new message; samples key, IV and sizes; i_aad carries AAD block 0
- i_pt_instance  in  1  marks the first plaintext block on i_plain_text
- i_cipher_key  in  128  AES-128 key, bit 0 = MSB/first bit
- i_iv  in  96  IV
- i_plain_text  in  128  plaintext block
- i_aad  in  128  AAD block
- i_plain_text_size  in  64  plaintext length in bits
- i_aad_size  in  64  AAD length in bits
- o_cipher_text  out  128  registered ciphertext block
- o_tag  out  128  registered authentication tag
- o_tag_ready  out  1  tag valid, held high

Behaviour:
- Reset (sync, highest priority): state=IDLE; o_cipher_text, o_tag, o_tag_ready, GHASH accumulator X, H, EKJ0 and counter all 0.
- Block counts: nA = ceil(aad_size/128), nP = ceil(pt_size/128), both from sizes latched at i_new_instance.
- Final partial block: bits at positions >= size mod 128 are forced to 0. For AAD this is before GHASH. For ciphertext it applies to both the output and the GHASH input.
- i_new_instance in any state aborts the current message and restarts. At that edge:
  - latch key and sizes;
  - H <= E(K, 0^128);
  - EKJ0 <= E(K, IV||0x00000001);
  - CTR <= IV||0x00000002;
  - o_tag_ready <= 0.
- Same-cycle use at i_new_instance: H and the key are used combinationally from i_cipher_key. If nA>0, X <= (0 ^ i_aad)·H and the AAD count is 1; otherwise X <= 0.
- States: IDLE, AAD, PT_WAIT, PT, LEN, DONE.
- AAD: each cycle X <= (X ^ aad_masked)·H. After the nA-th block, go to PT_WAIT. If nA ≤ 1, go from the new_instance cycle straight to PT_WAIT.
- PT_WAIT: AAD input is ignored. On i_pt_instance:
  - if nP=0, go to LEN;
  - else accept block 1 and go to PT.
- i_pt_instance is ignored in all other states.
- Per accepted PT block:
  - C = (P ^ E(K, CTR)) masked;
  - o_cipher_text <= C;
  - X <= (X ^ C)·H;
  - CTR low 32 bits += 1 mod 2^32 (inc32).
- Plaintext blocks are consecutive, one per cycle; after nP blocks go to LEN.
- LEN (one cycle): o_tag <= ((X ^ (aad_size64 || pt_size64))·H) ^ EKJ0; o_tag_ready <= 1; go to DONE.
- Latency: tag_ready rises at the 2nd edge after the edge accepting the last PT block.
- DONE: outputs hold until reset or i_new_instance.
- o_cipher_text holds its last value when no block is accepted.
- GF(2^128) multiply uses the bit-reflected SP 800-38D convention, with R = 0xE1||0^120. Bit 0 is the x^0 coefficient, i.e. the MSB of the big-endian block.
- AES: FIPS-197 AES-128 encryption, combinational, 10 rounds, on-the-fly key expansion.

Decomposition:
- Shared package gcm_pkg holds:
  - the block/key/IV width constants;
  - the state enum;
  - the R constant;
  - the functions gf128_mul, inc32 and mask_block.
- One sub-module, aes128_encrypt (combinational, key+block in, block out). Instantiate it twice: one for H, one for counter/J0 blocks.

Test Plan:
- Key 0, IV 0, sizes 0/0, new_instance, then pt_instance -> o_tag = 58e2fccefa7e3061367f1d57a4e7455a, o_tag_ready=1 two edges after pt_instance.
- Key 0, IV 0, aad_size 0, pt_size 128, PT 0 -> o_cipher_text = 0388dace60b6a392f328c2b971b2fe78; tag = ab6e47d42cec13bdf53a67b21257bddf.
- Key feffe9928665731c6d6a8f9467308308, IV cafebabefacedbaddecaf888, aad_size 0, pt_size 512, NIST test case 3 PT (d9313225…b16aedf5aa0de657ba637b391aafd255) -> first C block 42831ec2217774244b7221b784d0d49c; tag 4d5c2af327cd64a62cf35abd2ba6fab4.
- Same key and IV, AAD feedfacedeadbeeffeedfacedeadbeefabaddad2 (160 bits), 480-bit PT (test case 3 PT truncated) -> last C block ends 3d58e091 followed by 32 zero bits; tag 5bc94fbc3221a5db94fae95ae7121a47.
- Assert i_new_instance midway through the PT stream, then rerun test case 2 -> test case 2 results; o_tag_ready deasserted after the restart edge.
- Assert rst during AAD -> all outputs 0 next edge; a subsequent full run reproduces test case 3 exactly.

Source files
------------

// File: rtl/gcm_pkg.sv
// gcm_pkg: shared widths, FSM states and GF(2^128)/counter/mask helpers for gcm_aes
package gcm_pkg;
  localparam int BLK_W = 128;
  localparam int KEY_W = 128;
  localparam int IV_W = 96;
  localparam int SZ_W = 64;
  localparam logic [BLK_W-1:0] R = {8'he1, 120'd0};
  typedef enum logic [2:0] {IDLE, AAD, PT_WAIT, PT, LEN, DONE} state_t;
  function automatic logic [BLK_W-1:0] gf128_mul(input logic [BLK_W-1:0] a, input logic [BLK_W-1:0] b);
    logic [BLK_W-1:0] z, v;
    z = '0;
    v = b;
    for (int i = 0; i < BLK_W; i++) begin
      z = a[BLK_W-1-i] ? z ^ v : z;
      v = v[0] ? (v >> 1) ^ R : v >> 1;
    end
    return z;
  endfunction
  function automatic logic [BLK_W-1:0] inc32(input logic [BLK_W-1:0] c);
    return {c[BLK_W-1:32], c[31:0] + 32'd1};
  endfunction
  function automatic logic [BLK_W-1:0] mask_block(input logic [BLK_W-1:0] b, input logic [6:0] keep);
    return keep == 7'd0 ? b : b & ~({BLK_W{1'b1}} >> keep);
  endfunction
endpackage

// File: rtl/aes128_encrypt.sv
// aes128_encrypt: combinational FIPS-197 AES-128 encryption with on-the-fly key expansion
module aes128_encrypt
  import gcm_pkg::*;
(
  input  logic [BLK_W-1:0] key,
  input  logic [BLK_W-1:0] blk,
  output logic [BLK_W-1:0] out
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ t : p;
      t = xt(t);
    end
    return p;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq = x;
    inv = 8'd1;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = sbox(s[127-8*((i % 4) + 4*(((i / 4) + (i % 4)) % 4)) -: 8]);
    return o;
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'd0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  function automatic logic [127:0] encrypt(input logic [127:0] k_in, input logic [127:0] b);
    logic [127:0] s, k;
    logic [7:0] rc;
    k = k_in;
    s = b ^ k_in;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      k = next_key(k, rc);
      rc = xt(rc);
      s = sub_shift(s);
      s = (r < 10 ? mix_columns(s) : s) ^ k;
    end
    return s;
  endfunction
  assign out = encrypt(key, blk);
endmodule

// File: rtl/gcm_aes.sv
// gcm_aes: streaming AES-128 GCM authenticated encryptor (96-bit IV), one block per cycle
module gcm_aes
  import gcm_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_new_instance,
  input  logic             i_pt_instance,
  input  logic [KEY_W-1:0] i_cipher_key,
  input  logic [IV_W-1:0]  i_iv,
  input  logic [BLK_W-1:0] i_plain_text,
  input  logic [BLK_W-1:0] i_aad,
  input  logic [SZ_W-1:0]  i_plain_text_size,
  input  logic [SZ_W-1:0]  i_aad_size,
  output logic [BLK_W-1:0] o_cipher_text,
  output logic [BLK_W-1:0] o_tag,
  output logic             o_tag_ready
);
  function automatic logic [SZ_W-1:0] nblk(input logic [SZ_W-1:0] sz);
    return (sz >> 7) + {63'd0, |sz[6:0]};
  endfunction
  state_t state;
  logic [KEY_W-1:0] key_q, key_c;
  logic [SZ_W-1:0] aad_sz, pt_sz, cnt, n_a, n_p, n_a_new;
  logic [BLK_W-1:0] h, ekj0, ctr, x, h_c, h_e, ek, ek_blk, aad_m, ct, gh_in, gh;
  logic a_last, p_last, acc;
  assign key_c = i_new_instance ? i_cipher_key : key_q;
  assign ek_blk = i_new_instance ? {i_iv, 32'd1} : ctr;
  aes128_encrypt u_aes_h (.key(key_c), .blk({BLK_W{1'b0}}), .out(h_c));
  aes128_encrypt u_aes_ctr (.key(key_c), .blk(ek_blk), .out(ek));
  assign h_e = i_new_instance ? h_c : h;
  assign n_a = nblk(aad_sz);
  assign n_p = nblk(pt_sz);
  assign n_a_new = nblk(i_aad_size);
  assign a_last = i_new_instance ? n_a_new == 64'd1 : cnt + 64'd1 == n_a;
  assign aad_m = mask_block(i_aad, a_last ? (i_new_instance ? i_aad_size[6:0] : aad_sz[6:0]) : 7'd0);
  assign p_last = state == PT_WAIT ? n_p == 64'd1 : cnt + 64'd1 == n_p;
  assign ct = mask_block(i_plain_text ^ ek, p_last ? pt_sz[6:0] : 7'd0);
  assign acc = (state == PT_WAIT && i_pt_instance && n_p != '0) || (state == PT && cnt != n_p);
  assign gh_in = i_new_instance ? aad_m
               : state == AAD ? x ^ aad_m
               : state == LEN ? x ^ {aad_sz, pt_sz}
               : x ^ ct;
  assign gh = gf128_mul(gh_in, h_e);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      key_q <= '0;
      aad_sz <= '0;
      pt_sz <= '0;
      cnt <= '0;
      h <= '0;
      ekj0 <= '0;
      ctr <= '0;
      x <= '0;
      o_cipher_text <= '0;
      o_tag <= '0;
      o_tag_ready <= 1'b0;
    end else if (i_new_instance) begin
      key_q <= i_cipher_key;
      aad_sz <= i_aad_size;
      pt_sz <= i_plain_text_size;
      h <= h_c;
      ekj0 <= ek;
      ctr <= {i_iv, 32'd2};
      o_tag_ready <= 1'b0;
      x <= n_a_new != '0 ? gh : '0;
      cnt <= n_a_new != '0 ? 64'd1 : 64'd0;
      state <= n_a_new > 64'd1 ? AAD : PT_WAIT;
    end else begin
      if (acc) begin
        o_cipher_text <= ct;
        x <= gh;
        ctr <= inc32(ctr);
        cnt <= state == PT_WAIT ? 64'd1 : cnt + 64'd1;
      end
      case (state)
        AAD: begin
          x <= gh;
          cnt <= cnt + 64'd1;
          state <= a_last ? PT_WAIT : AAD;
        end
        PT_WAIT: state <= !i_pt_instance ? PT_WAIT : n_p == '0 ? LEN : PT;
        PT: state <= cnt == n_p ? LEN : PT;
        LEN: begin
          o_tag <= gh ^ ekj0;
          o_tag_ready <= 1'b1;
          state <= DONE;
        end
        default: state <= state;
      endcase
    end
  end
endmodule

// File: tb/tb_gcm_aes.sv
// tb_gcm_aes: directed NIST vectors plus randomized messages checked against a behavioural GCM model
module tb_gcm_aes;
  logic clk = 1'b0;
  logic rst, i_new_instance, i_pt_instance, o_tag_ready;
  logic [127:0] i_cipher_key, i_plain_text, i_aad, o_cipher_text, o_tag;
  logic [95:0] i_iv;
  logic [63:0] i_plain_text_size, i_aad_size;
  int n_asrt = 0;
  int n_fail = 0;
  int got_lat;
  logic [127:0] aad_blk[8], pt_blk[8], got_c[8], exp_c[8], exp_tag;
  logic [7:0] sb[256];
  localparam logic [127:0] K3 = 128'hfeffe9928665731c6d6a8f9467308308;
  localparam logic [95:0] IV3 = 96'hcafebabefacedbaddecaf888;
  gcm_aes dut (
    .clk(clk), .rst(rst), .i_new_instance(i_new_instance), .i_pt_instance(i_pt_instance),
    .i_cipher_key(i_cipher_key), .i_iv(i_iv), .i_plain_text(i_plain_text), .i_aad(i_aad),
    .i_plain_text_size(i_plain_text_size), .i_aad_size(i_aad_size),
    .o_cipher_text(o_cipher_text), .o_tag(o_tag), .o_tag_ready(o_tag_ready)
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  // S-box by walking the multiplicative group with generator 3 and its inverse
  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sb[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask
  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] blk);
    logic [7:0] w[176];
    logic [7:0] s[16];
    logic [7:0] t[16];
    logic [7:0] a0, a1, a2, a3, rc;
    logic [127:0] o;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) w[i] = key[127-8*i -: 8];
    for (int i = 16; i < 176; i += 4) begin
      a0 = w[i-4]; a1 = w[i-3]; a2 = w[i-2]; a3 = w[i-1];
      if (i % 16 == 0) begin
        {a0, a1, a2, a3} = {sb[a1] ^ rc, sb[a2], sb[a3], sb[a0]};
        rc = xt(rc);
      end
      w[i] = w[i-16] ^ a0; w[i+1] = w[i-15] ^ a1; w[i+2] = w[i-14] ^ a2; w[i+3] = w[i-13] ^ a3;
    end
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[16*r+i];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction
  function automatic logic [127:0] rev(input logic [127:0] v);
    logic [127:0] o;
    for (int i = 0; i < 128; i++) o[i] = v[127-i];
    return o;
  endfunction
  // carry-less polynomial product reduced by x^128 + x^7 + x^2 + x + 1
  function automatic logic [127:0] gmul_ref(input logic [127:0] a, input logic [127:0] b);
    logic [255:0] p;
    logic [127:0] ra, rb;
    p = '0;
    ra = rev(a);
    rb = rev(b);
    for (int k = 0; k < 128; k++) if (rb[k]) p = p ^ ({128'd0, ra} << k);
    for (int k = 254; k >= 128; k--) if (p[k]) begin
      p[k] = 1'b0;
      p[k-121] = ~p[k-121];
      p[k-126] = ~p[k-126];
      p[k-127] = ~p[k-127];
      p[k-128] = ~p[k-128];
    end
    return rev(p[127:0]);
  endfunction
  function automatic logic [127:0] trim(input logic [127:0] b, input logic [63:0] bits);
    logic [127:0] o;
    o = b;
    for (int i = 0; i < 128; i++) if (64'(i) >= bits) o[127-i] = 1'b0;
    return o;
  endfunction
  task automatic model(input logic [127:0] key, input logic [95:0] iv, input logic [63:0] asz, input logic [63:0] psz);
    logic [127:0] h, x;
    int na, np;
    na = int'((asz + 64'd127) >> 7);
    np = int'((psz + 64'd127) >> 7);
    h = aes_ref(key, 128'd0);
    x = '0;
    for (int i = 0; i < na; i++) x = gmul_ref(x ^ trim(aad_blk[i], asz - 64'(128 * i)), h);
    for (int i = 0; i < np; i++) begin
      exp_c[i] = trim(pt_blk[i] ^ aes_ref(key, {iv, 32'd2 + 32'(i)}), psz - 64'(128 * i));
      x = gmul_ref(x ^ exp_c[i], h);
    end
    exp_tag = gmul_ref(x ^ {asz, psz}, h) ^ aes_ref(key, {iv, 32'd1});
  endtask
  task automatic run_msg(input logic [127:0] key, input logic [95:0] iv, input logic [63:0] asz,
                         input logic [63:0] psz, input int stop);
    int na, np;
    na = int'((asz + 64'd127) >> 7);
    np = int'((psz + 64'd127) >> 7);
    i_cipher_key = key;
    i_iv = iv;
    i_aad_size = asz;
    i_plain_text_size = psz;
    i_aad = aad_blk[0];
    i_new_instance = 1'b1;
    @(posedge clk); #1;
    i_new_instance = 1'b0;
    i_cipher_key = rnd128();
    i_iv = rnd128()[95:0];
    i_aad_size = 64'($urandom);
    i_plain_text_size = 64'($urandom);
    chk("ready_clr_on_start", 128'(o_tag_ready), 128'd0);
    for (int i = 1; i < na; i++) begin
      i_aad = aad_blk[i];
      @(posedge clk); #1;
    end
    i_aad = rnd128();
    i_plain_text = rnd128();
    @(posedge clk); #1;
    i_pt_instance = 1'b1;
    i_plain_text = pt_blk[0];
    @(posedge clk); #1;
    i_pt_instance = 1'b0;
    if (np > 0) got_c[0] = o_cipher_text;
    for (int i = 1; i < np && i < stop; i++) begin
      i_plain_text = pt_blk[i];
      @(posedge clk); #1;
      got_c[i] = o_cipher_text;
    end
    i_plain_text = rnd128();
    i_aad = rnd128();
    got_lat = 0;
    if (stop >= np)
      while (!o_tag_ready && got_lat < 8) begin
        @(posedge clk); #1;
        got_lat++;
      end
  endtask
  initial begin
    logic [127:0] key;
    logic [95:0] iv;
    logic [63:0] asz, psz;
    int np;
    build_sbox();
    rst = 1'b1;
    i_new_instance = 1'b0;
    i_pt_instance = 1'b0;
    i_cipher_key = '0;
    i_iv = '0;
    i_plain_text = '0;
    i_aad = '0;
    i_plain_text_size = '0;
    i_aad_size = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ct", o_cipher_text, 128'd0);
    chk("reset_tag", o_tag, 128'd0);
    chk("reset_ready", 128'(o_tag_ready), 128'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      aad_blk[i] = rnd128();
      pt_blk[i] = rnd128();
    end
    run_msg(128'd0, 96'd0, 64'd0, 64'd0, 8);
    chk("tc1_tag", o_tag, 128'h58e2fccefa7e3061367f1d57a4e7455a);
    chk("tc1_latency", 128'(got_lat), 128'd1);
    pt_blk[0] = '0;
    run_msg(128'd0, 96'd0, 64'd0, 64'd128, 8);
    chk("tc2_ct", got_c[0], 128'h0388dace60b6a392f328c2b971b2fe78);
    chk("tc2_tag", o_tag, 128'hab6e47d42cec13bdf53a67b21257bddf);
    chk("tc2_latency", 128'(got_lat), 128'd2);
    pt_blk[0] = 128'hd9313225f88406e5a55909c5aff5269a;
    pt_blk[1] = 128'h86a7a9531534f7da2e4c303d8a318a72;
    pt_blk[2] = 128'h1c3c0c95956809532fcf0e2449a6b525;
    pt_blk[3] = 128'hb16aedf5aa0de657ba637b391aafd255;
    run_msg(K3, IV3, 64'd0, 64'd512, 8);
    chk("tc3_ct0", got_c[0], 128'h42831ec2217774244b7221b784d0d49c);
    chk("tc3_ct3", got_c[3], 128'h1ba30b396a0aac973d58e091473f5985);
    chk("tc3_tag", o_tag, 128'h4d5c2af327cd64a62cf35abd2ba6fab4);
    @(posedge clk); #1;
    chk("tc3_ready_hold", 128'(o_tag_ready), 128'd1);
    chk("tc3_ct_hold", o_cipher_text, 128'h1ba30b396a0aac973d58e091473f5985);
    aad_blk[0] = 128'hfeedfacedeadbeeffeedfacedeadbeef;
    aad_blk[1] = {32'habaddad2, rnd128()[95:0]};
    run_msg(K3, IV3, 64'd160, 64'd480, 8);
    chk("tc4_ct3", got_c[3], {96'h1ba30b396a0aac973d58e091, 32'd0});
    chk("tc4_tag", o_tag, 128'h5bc94fbc3221a5db94fae95ae7121a47);
    run_msg(K3, IV3, 64'd0, 64'd512, 2);
    chk("abort_ready_low", 128'(o_tag_ready), 128'd0);
    pt_blk[0] = '0;
    run_msg(128'd0, 96'd0, 64'd0, 64'd128, 8);
    chk("abort_tc2_ct", got_c[0], 128'h0388dace60b6a392f328c2b971b2fe78);
    chk("abort_tc2_tag", o_tag, 128'hab6e47d42cec13bdf53a67b21257bddf);
    i_cipher_key = K3;
    i_iv = IV3;
    i_aad_size = 64'd160;
    i_plain_text_size = 64'd480;
    i_aad = aad_blk[0];
    i_new_instance = 1'b1;
    @(posedge clk); #1;
    i_new_instance = 1'b0;
    i_aad = aad_blk[1];
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_ct", o_cipher_text, 128'd0);
    chk("rst_mid_tag", o_tag, 128'd0);
    chk("rst_mid_ready", 128'(o_tag_ready), 128'd0);
    pt_blk[0] = 128'hd9313225f88406e5a55909c5aff5269a;
    pt_blk[1] = 128'h86a7a9531534f7da2e4c303d8a318a72;
    pt_blk[2] = 128'h1c3c0c95956809532fcf0e2449a6b525;
    pt_blk[3] = 128'hb16aedf5aa0de657ba637b391aafd255;
    run_msg(K3, IV3, 64'd0, 64'd512, 8);
    chk("post_rst_ct0", got_c[0], 128'h42831ec2217774244b7221b784d0d49c);
    chk("post_rst_ct3", got_c[3], 128'h1ba30b396a0aac973d58e091473f5985);
    chk("post_rst_tag", o_tag, 128'h4d5c2af327cd64a62cf35abd2ba6fab4);
    for (int n = 0; n < 6; n++) begin
      key = rnd128();
      iv = rnd128()[95:0];
      asz = 64'($urandom_range(0, 1024));
      psz = 64'($urandom_range(0, 1024));
      np = int'((psz + 64'd127) >> 7);
      for (int i = 0; i < 8; i++) begin
        aad_blk[i] = rnd128();
        pt_blk[i] = rnd128();
      end
      model(key, iv, asz, psz);
      run_msg(key, iv, asz, psz, 8);
      for (int i = 0; i < np; i++) chk($sformatf("rand%0d_ct%0d", n, i), got_c[i], exp_c[i]);
      chk($sformatf("rand%0d_tag", n), o_tag, exp_tag);
      chk($sformatf("rand%0d_latency", n), 128'(got_lat), np == 0 ? 128'd1 : 128'd2);
      @(posedge clk); #1;
      chk($sformatf("rand%0d_ready_hold", n), 128'(o_tag_ready), 128'd1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
